// File: rtl/kronos_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_mem_pkg
//  Description : Shared types and helpers for the Kronos dual-port memory.
//                Holds the default address width, word geometry, request
//                bundle type and the per-bit strobe merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package kronos_mem_pkg;

    localparam int unsigned AW        = 20;
    localparam int unsigned WordBytes = 4;

    typedef logic [AW-1:0] addr_t;
    typedef logic [31:0]   data_t;
    typedef logic [31:0]   strb_t;

    typedef struct packed {
        logic  req;
        addr_t addr;
        data_t wdata;
        strb_t strb;
        logic  we;
    } mem_req_t;

    // Bits with a set strobe take the new data; all others keep the old word.
    function automatic data_t apply_strb(input data_t old_word,
                                         input data_t wdata,
                                         input strb_t strb);
        return (wdata & strb) | (old_word & ~strb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kronos_dual_port_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_dual_port_mem_if
//  Description : req/gnt memory port bundle. One instance per memory port.
//                master : drives req, addr, wdata, strb, we
//                slave  : drives gnt, rdata, rvalid
//  Revision    : 1.0 - initial release
// ============================================================================
interface kronos_dual_port_mem_if
    import kronos_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = AW
);
    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] addr;
    data_t                wdata;
    strb_t                strb;
    logic                 we;
    data_t                rdata;
    logic                 rvalid;

    modport master (
        output req, addr, wdata, strb, we,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, addr, wdata, strb, we,
        output gnt, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/kronos_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_mem_port_ctrl
//  Description : Per-port grant controller. Counts WaitCyc idle cycles while
//                req is held, then grants for one cycle; registers rvalid as
//                the grant delayed by one cycle.
//  Ports       : clk_i, rst_i (async, active-high), req_i -> gnt_o, rvalid_o
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_mem_port_ctrl #(
    parameter int unsigned WaitCyc = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic gnt_o,
    output logic rvalid_o
);

    logic gnt;
    logic rvalid_d;
    logic rvalid_q;

    generate
        if (WaitCyc == 0) begin : g_no_wait
            // Reset masks the grant so nothing is accepted while rst_i is high.
            assign gnt = req_i & ~rst_i;
        end else begin : g_wait
            localparam int unsigned CntW = $clog2(WaitCyc + 1);

            logic [CntW-1:0] cnt_d;
            logic [CntW-1:0] cnt_q;
            logic            hit;

            always_comb begin
                cnt_d = cnt_q;
                hit   = 1'b0;
                if (!req_i) begin
                    // A withdrawn request is abandoned; restart the count.
                    cnt_d = '0;
                end else if (cnt_q == CntW'(WaitCyc)) begin
                    hit   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign gnt = hit & ~rst_i;
        end
    endgenerate

    assign rvalid_d = gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;

endmodule
`default_nettype wire

// File: rtl/kronos_dual_port_mem.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_dual_port_mem
//  Description : Dual-port 32-bit word memory behind the Kronos core wrapper.
//                Instruction and data ports each have a req/gnt handshake
//                with programmable grant wait states, per-bit write strobes
//                and registered read data (valid the cycle after the grant).
//  Ports       : clk_i        clock, rising edge
//                rst_i        asynchronous active-high reset
//                instr_mem    instruction port (slave side)
//                data_mem     data port (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_dual_port_mem
    import kronos_mem_pkg::*;
#(
    parameter int unsigned AddrWidth    = AW,
    parameter int unsigned InstrWaitCyc = 0,
    parameter int unsigned DataWaitCyc  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    kronos_dual_port_mem_if.slave  instr_mem,
    kronos_dual_port_mem_if.slave  data_mem
);

    localparam int unsigned ByteOffW = $clog2(WordBytes);
    localparam int unsigned IdxW     = AddrWidth - ByteOffW;
    localparam int unsigned Depth    = 2 ** IdxW;

    data_t mem [Depth];

    logic            instr_gnt;
    logic            data_gnt;
    logic            instr_rvalid;
    logic            data_rvalid;
    logic [IdxW-1:0] instr_idx;
    logic [IdxW-1:0] data_idx;
    logic            instr_wr;
    logic            data_wr;
    logic            instr_rd;
    logic            data_rd;
    data_t           instr_wr_word;
    data_t           data_base;
    data_t           data_wr_word;
    data_t           instr_rdata_d;
    data_t           instr_rdata_q;
    data_t           data_rdata_d;
    data_t           data_rdata_q;
    logic            unused_addr_lsbs;

    kronos_mem_port_ctrl #(.WaitCyc(InstrWaitCyc)) u_instr_ctrl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (instr_mem.req),
        .gnt_o   (instr_gnt),
        .rvalid_o(instr_rvalid)
    );

    kronos_mem_port_ctrl #(.WaitCyc(DataWaitCyc)) u_data_ctrl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (data_mem.req),
        .gnt_o   (data_gnt),
        .rvalid_o(data_rvalid)
    );

    // Upper address bits beyond the array simply do not exist, so addresses
    // wrap modulo the depth.
    assign instr_idx        = instr_mem.addr[AddrWidth-1:ByteOffW];
    assign data_idx         = data_mem.addr[AddrWidth-1:ByteOffW];
    assign unused_addr_lsbs = ^{instr_mem.addr[ByteOffW-1:0], data_mem.addr[ByteOffW-1:0]};

    always_comb begin
        instr_wr      = instr_gnt & instr_mem.we;
        data_wr       = data_gnt & data_mem.we;
        instr_rd      = instr_gnt & ~instr_mem.we;
        data_rd       = data_gnt & ~data_mem.we;
        instr_wr_word = apply_strb(mem[instr_idx], instr_mem.wdata, instr_mem.strb);
        // Same-word double write: the data strobe is layered on top of the
        // instruction result, so overlapping bits go to the data port while
        // instruction-only bits still land.
        data_base     = (instr_wr && (instr_idx == data_idx)) ? instr_wr_word : mem[data_idx];
        data_wr_word  = apply_strb(data_base, data_mem.wdata, data_mem.strb);
        instr_rdata_d = instr_rd ? mem[instr_idx] : instr_rdata_q;
        data_rdata_d  = data_rd ? mem[data_idx] : data_rdata_q;
    end

    // Array has no reset; contents survive rst_i. The data write is issued
    // last so it overrides the instruction write on a shared word.
    always_ff @(posedge clk_i) begin
        if (instr_wr) begin
            mem[instr_idx] <= instr_wr_word;
        end
        if (data_wr) begin
            mem[data_idx] <= data_wr_word;
        end
    end

    // Reads sample the array before this edge's writes land, giving
    // read-before-write on cross-port collisions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign instr_mem.gnt    = instr_gnt;
    assign instr_mem.rvalid = instr_rvalid;
    assign instr_mem.rdata  = instr_rdata_q;
    assign data_mem.gnt     = data_gnt;
    assign data_mem.rvalid  = data_rvalid;
    assign data_mem.rdata   = data_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_kronos_dual_port_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kronos_dual_port_mem
//  Description : Self-checking bench. dut0 has zero wait states on both
//                ports and is run cycle-by-cycle against an associative-array
//                reference memory; dut1 (instr wait 2, data wait 3) exercises
//                grant latency and request abandonment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kronos_dual_port_mem;
    import kronos_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kronos_dual_port_mem_if #(.AddrWidth(20)) if0i ();
    kronos_dual_port_mem_if #(.AddrWidth(20)) if0d ();
    kronos_dual_port_mem_if #(.AddrWidth(20)) if1i ();
    kronos_dual_port_mem_if #(.AddrWidth(20)) if1d ();

    kronos_dual_port_mem #(.AddrWidth(20), .InstrWaitCyc(0), .DataWaitCyc(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .instr_mem(if0i.slave), .data_mem(if0d.slave)
    );

    kronos_dual_port_mem #(.AddrWidth(20), .InstrWaitCyc(2), .DataWaitCyc(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .instr_mem(if1i.slave), .data_mem(if1d.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference memory for dut0 ----------------
    logic [31:0] model [int unsigned];
    logic [31:0] exp_irdata  = 32'h0;
    logic [31:0] exp_drdata  = 32'h0;
    logic        exp_irvalid = 1'b0;
    logic        exp_drvalid = 1'b0;

    // 20-bit byte address space -> 2**18 words; higher address bits wrap.
    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % (2 ** 18);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model.exists(widx(a))) return model[widx(a)];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] st);
        logic [31:0] w;
        w = model_rd(a);
        for (int b = 0; b < 32; b++) begin
            if (st[b]) w[b] = wd[b];
        end
        model[widx(a)] = w;
    endtask

    // One dut0 cycle: check what the previous edge produced, apply new
    // inputs, check same-cycle grants, then advance the reference.
    task automatic step(input logic ireq, input logic iwe, input logic [31:0] ia,
                        input logic [31:0] iwd, input logic [31:0] ist,
                        input logic dreq, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [31:0] dst);
        @(negedge clk);
        check_val("i_rvalid", {31'b0, if0i.rvalid}, {31'b0, exp_irvalid});
        check_val("i_rdata",  if0i.rdata, exp_irdata);
        check_val("d_rvalid", {31'b0, if0d.rvalid}, {31'b0, exp_drvalid});
        check_val("d_rdata",  if0d.rdata, exp_drdata);
        if0i.req = ireq; if0i.we = iwe; if0i.addr = ia[19:0]; if0i.wdata = iwd; if0i.strb = ist;
        if0d.req = dreq; if0d.we = dwe; if0d.addr = da[19:0]; if0d.wdata = dwd; if0d.strb = dst;
        #1;
        check_val("i_gnt", {31'b0, if0i.gnt}, {31'b0, ireq});
        check_val("d_gnt", {31'b0, if0d.gnt}, {31'b0, dreq});
        // Reads see the memory before either write; instr write then data
        // write so the data port owns overlapping bits.
        if (ireq && !iwe) exp_irdata = model_rd(ia);
        if (dreq && !dwe) exp_drdata = model_rd(da);
        exp_irvalid = ireq;
        exp_drvalid = dreq;
        if (ireq && iwe) model_wr(ia, iwd, ist);
        if (dreq && dwe) model_wr(da, dwd, dst);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] st);
        step(0, 0, 0, 0, 0, 1, 1, a, wd, st);
    endtask

    task automatic dread(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 1, 0, a, 0, 0);
    endtask

    task automatic iread(input logic [31:0] a);
        step(1, 0, a, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- dut1 helpers ----------------
    task automatic drive1(input bit dport, input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] st);
        if (dport) begin
            if1d.req = req; if1d.we = we; if1d.addr = a[19:0]; if1d.wdata = wd; if1d.strb = st;
        end else begin
            if1i.req = req; if1i.we = we; if1i.addr = a[19:0]; if1i.wdata = wd; if1i.strb = st;
        end
    endtask

    function automatic logic gnt1(input bit dport);
        return dport ? if1d.gnt : if1i.gnt;
    endfunction

    function automatic logic rvalid1(input bit dport);
        return dport ? if1d.rvalid : if1i.rvalid;
    endfunction

    function automatic logic [31:0] rdata1(input bit dport);
        return dport ? if1d.rdata : if1i.rdata;
    endfunction

    // Hold a request until granted (bounded), check the wait, then the
    // rvalid pulse and, for reads, the returned word.
    task automatic txn1(input bit dport, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_wait, input logic [31:0] exp_rd);
        int waited;
        waited = 0;
        @(negedge clk);
        drive1(dport, 1, we, a, wd, 32'hFFFF_FFFF);
        #1;
        while (gnt1(dport) !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_val("w_wait_cycles", waited, exp_wait);
        @(negedge clk);
        drive1(dport, 0, 0, 0, 0, 0);
        #1;
        check_val("w_rvalid_pulse", {31'b0, rvalid1(dport)}, 32'd1);
        if (!we) check_val("w_rdata", rdata1(dport), exp_rd);
        @(negedge clk);
        #1;
        check_val("w_rvalid_drop", {31'b0, rvalid1(dport)}, 32'd0);
    endtask

    // ---------------- protocol assertions (dut1 data port) ----------------
    bit          allow_abandon = 1'b0;
    logic        p_req  = 1'b0;
    logic        p_gnt  = 1'b0;
    logic [19:0] p_addr = '0;
    logic        p_we   = 1'b0;
    logic [31:0] p_wd   = '0;
    logic [31:0] p_st   = '0;

    always @(posedge clk) begin
        if (!rst && p_req && !p_gnt) begin
            assert (allow_abandon || if1d.req) else $error("req dropped before gnt");
            assert (!if1d.req || (if1d.addr == p_addr && if1d.we == p_we &&
                                  if1d.wdata == p_wd && if1d.strb == p_st))
                else $error("request fields changed before gnt");
        end
        assert (!if1d.req || !$isunknown(if1d.addr)) else $error("X on addr during req");
        p_req  <= if1d.req;
        p_gnt  <= if1d.gnt;
        p_addr <= if1d.addr;
        p_we   <= if1d.we;
        p_wd   <= if1d.wdata;
        p_st   <= if1d.strb;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ia, da, ist, dst;

        drive1(0, 0, 0, 0, 0, 0);
        drive1(1, 0, 0, 0, 0, 0);
        {if0i.req, if0i.we, if0i.addr, if0i.wdata, if0i.strb} = '0;
        {if0d.req, if0d.we, if0d.addr, if0d.wdata, if0d.strb} = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        idle();

        // preload words 0..15 so random reads never see unwritten storage
        for (int i = 0; i < 16; i++) dwrite(i * 4, $urandom, 32'hFFFF_FFFF);

        // full write then read
        dwrite(32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        dread(32'h100);
        idle();
        check_val("full_write_rd", if0d.rdata, 32'hDEAD_BEEF);

        // partial strobe
        dwrite(32'h100, 32'h1234_5678, 32'h0000_FF00);
        dread(32'h100);
        idle();
        check_val("partial_strobe", if0d.rdata, 32'hDEAD_56EF);

        // cross-port collision: read-before-write
        dwrite(32'h200, 32'h1111_1111, 32'hFFFF_FFFF);
        step(1, 0, 32'h200, 0, 0, 1, 1, 32'h200, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        iread(32'h200);
        idle();
        check_val("collision_new", if0i.rdata, 32'hA5A5_A5A5);

        // same-word double write: overlapping bits from the data port
        step(1, 1, 32'h300, 32'hFFFF_FFFF, 32'h00FF_FF00, 1, 1, 32'h300, 32'h0000_0000, 32'hFFFF_0000);
        step(0, 0, 0, 0, 0, 1, 1, 32'h300, 32'h0, 32'h0000_0000);
        dread(32'h300);
        idle();

        // address wrap
        dwrite(32'h0_0004, 32'h600D_CAFE, 32'hFFFF_FFFF);
        dread(32'h10_0004);
        idle();
        check_val("wrap_read", if0d.rdata, 32'h600D_CAFE);

        // randomized traffic on both ports over a small window of words
        for (int n = 0; n < 400; n++) begin
            ia  = $urandom & 32'h00F0_003F;
            da  = $urandom & 32'h00F0_003F;
            ist = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
            dst = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), ia, $urandom, ist,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1), da, $urandom, dst);
        end
        idle();

        // reset mid-simulation
        dwrite(32'h10, 32'h0BAD_F00D, 32'hFFFF_FFFF);
        iread(32'h10);
        @(negedge clk);
        check_val("pre_rst_rvalid", {31'b0, if0i.rvalid}, 32'd1);
        check_val("pre_rst_rdata", if0i.rdata, 32'h0BAD_F00D);
        if0i.req = 1'b0;
        if0d.req = 1'b1; if0d.we = 1'b0; if0d.addr = 20'h100;
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_gnt", {31'b0, if0d.gnt}, 32'd0);
        check_val("rst_rvalid", {31'b0, if0i.rvalid}, 32'd0);
        check_val("rst_rdata", if0i.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if0d.req = 1'b0;
        exp_irdata = 32'h0; exp_drdata = 32'h0;
        exp_irvalid = 1'b0; exp_drvalid = 1'b0;
        idle();
        iread(32'h10);
        idle();
        check_val("post_rst_readback", if0i.rdata, 32'h0BAD_F00D);

        // wait states on dut1: data wait 3, instr wait 2
        txn1(1, 1, 32'h40, 32'hCAFE_F00D, 3, 32'h0);
        txn1(1, 0, 32'h40, 32'h0, 3, 32'hCAFE_F00D);

        // abandoned write: req held for two cycles then withdrawn
        allow_abandon = 1'b1;
        @(negedge clk);
        drive1(1, 1, 1, 32'h40, 32'hBAD0_BAD0, 32'hFFFF_FFFF);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val("abandon_gnt", {31'b0, if1d.gnt}, 32'd0);
            @(negedge clk);
        end
        drive1(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val("abandon_rvalid", {31'b0, if1d.rvalid}, 32'd0);
            @(negedge clk);
        end
        allow_abandon = 1'b0;
        txn1(1, 0, 32'h40, 32'h0, 3, 32'hCAFE_F00D);
        txn1(0, 0, 32'h40, 32'h0, 2, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
